fir_sample_buffer: RTL and testbench
====================================

FIR_SAMPLE_BUFFER -- requirements
Module: fir_sample_buffer

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 18, sample width.
- ROWS, 4096, rows per bank; 4 banks hold 4*ROWS = 16384 samples.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- sample_in  in  18  new input sample, signed.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  block accepts sample_in this cycle.
- datain_ready  out  1  one-cycle pulse that starts the downstream FIR MAC.
- mac_done  in  1  one-cycle pulse from the MAC when its output sample is ready.
- rd_addr  in  12  word read address from the MAC (0 = newest four samples).
- rd_data  out  72  four samples; [71:54] newest ... [17:0] oldest.
- overrun  out  1  sticky flag: a sample was dropped.
- init_done  out  1  buffer zeroing is complete.

Function
REQ-003 Storage SHALL be 4 banks of ROWS x 18; absolute sample index i (14-bit) SHALL map to bank i[1:0], row i[13:2].
REQ-004 A 14-bit pointer ptr SHALL hold the index of the newest sample; a write SHALL go to index ptr+1, then ptr <= ptr+1, with modulo-16384 wrap.
REQ-005 rd_data lane j (j = 0..3, j = 0 newest) SHALL return the sample at index ptr - 4*rd_addr - j, modulo 16384.
REQ-006 Each bank k SHALL compute its row from lane j = (ptr[1:0] - k) mod 4.
REQ-007 Reads SHALL be synchronous with exactly 1 cycle of latency: rd_addr in cycle t gives rd_data in cycle t+1.
REQ-008 The lane-rotation select SHALL be registered alongside the read, so the output mux matches the data it steers.
REQ-009 A 1-deep pending register SHALL capture sample_in when sample_valid and sample_ready are both high.
REQ-010 sample_ready SHALL equal init_done AND pending-empty.
REQ-011 When sample_valid is high and sample_ready is low, the sample SHALL be dropped and overrun SHALL set; overrun clears only on reset.
REQ-012 FSM states SHALL be INIT, IDLE, WRITE, START, BUSY, with these transitions:
- INIT -> IDLE after the last row is zeroed.
- IDLE -> WRITE when pending is full.
- WRITE writes the pending sample, advances ptr, clears pending, -> START.
- START drives datain_ready high for 1 cycle, -> BUSY.
- BUSY -> IDLE on mac_done.
REQ-013 INIT SHALL write 0 to row r of all 4 banks in cycle r, for r = 0..ROWS-1 (4096 cycles), then set init_done.
REQ-014 With the FSM in IDLE and pending empty, a sample accepted in cycle t SHALL produce datain_ready in cycle t+3.
REQ-015 Memory SHALL NOT be written in BUSY; a sample accepted during BUSY SHALL wait in pending until BUSY exits.
REQ-016 A mac_done outside BUSY SHALL be ignored.
REQ-017 rd_addr SHALL be honoured in every state; data read during WRITE or INIT is don't-care.

Reset
REQ-018 On reset the block SHALL set: state=INIT, ptr=16383 (so the first sample lands at index 0), pending empty, init row counter 0.
REQ-019 On reset all outputs SHALL be: sample_ready=0, datain_ready=0, overrun=0, init_done=0, rd_data=0.
REQ-020 Reset asserted in any state, including mid-INIT and BUSY, SHALL restart INIT and SHALL discard the pending sample.

Structure
REQ-021 A shared package SHALL hold: DATA_W, ROWS, lane count 4, PTR_W=14, and the FSM state encoding.
REQ-022 One sub-module, fir_sample_bank (ROWS x 18, 1 write port, 1 synchronous read port), SHALL be instantiated 4 times.

Verification
REQ-023 Reset, then wait 4096 cycles -> init_done=1 and sample_ready=1; rd_addr=0..4095 all return rd_data=0.
REQ-024 Write 1 sample, 0x00001 -> datain_ready 3 cycles after acceptance; rd_addr=0 returns {0x00001,0,0,0}.
REQ-025 Write samples 1..5 (mac_done after each) -> rd_addr=0 returns {5,4,3,2}; rd_addr=1 returns {1,0,0,0}.
REQ-026 Write 16385 samples, value = index+1 -> rd_addr=0 newest is 16385 (masked to 18 bits); rd_addr=4095 lane 3 is 2; ptr has wrapped to 0.
REQ-027 Apply 3 samples during BUSY -> the 1st is held in pending, the 2nd and 3rd are dropped, overrun=1; after mac_done exactly 1 further datain_ready pulse follows.
REQ-028 Assert reset during BUSY with pending full -> state INIT, pending cleared, overrun=0, no datain_ready for 4096 cycles.

Source files
------------

// File: rtl/fir_sample_buffer_pkg.sv
// Shared constants and FSM encoding for the FIR sample buffer and its banks.
package fir_sample_buffer_pkg;

  localparam int SAMPLE_W  = 18;
  localparam int LANES     = 4;
  localparam int PTR_W     = 14;
  localparam int BANK_ROWS = 1 << (PTR_W - 2);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WRITE = 3'd2,
    ST_START = 3'd3,
    ST_BUSY  = 3'd4
  } state_t;

endpackage

// File: rtl/fir_sample_bank.sv
// One sample bank: single write port, synchronous read port (read-before-write).
module fir_sample_bank
  import fir_sample_buffer_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int ROWS   = BANK_ROWS
) (
  input  logic                      clock,
  input  logic                      we,
  input  logic [$clog2(ROWS)-1:0]   waddr,
  input  logic signed [DATA_W-1:0]  wdata,
  input  logic [$clog2(ROWS)-1:0]   raddr,
  output logic signed [DATA_W-1:0]  rdata
);

  logic signed [DATA_W-1:0] mem [ROWS];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fir_sample_buffer.sv
// Circular sample history for an FIR MAC: four interleaved banks give four
// consecutive samples per read word, newest first relative to the write pointer.
module fir_sample_buffer
  import fir_sample_buffer_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int ROWS   = BANK_ROWS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [DATA_W-1:0]   sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic                       datain_ready,
  input  logic                       mac_done,
  input  logic [$clog2(ROWS)-1:0]    rd_addr,
  output logic [LANES*DATA_W-1:0]    rd_data,
  output logic                       overrun,
  output logic                       init_done
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int IDX_W = ROW_W + 2;

  state_t state, state_next;

  logic [IDX_W-1:0]         ptr;
  logic [IDX_W-1:0]         wr_idx;
  logic [ROW_W-1:0]         init_row;
  logic                     pend_full;
  logic signed [DATA_W-1:0] pend_data;
  logic                     accept;
  logic                     init_wr;
  logic                     pend_wr;
  logic [ROW_W-1:0]         wr_row;
  logic signed [DATA_W-1:0] wr_data;
  logic [LANES-1:0]         bank_we;
  logic signed [DATA_W-1:0] bank_q [LANES];
  logic [1:0]               rot_p1;
  logic                     rd_vld_p1;

  assign sample_ready = init_done & ~pend_full;
  assign accept       = sample_valid & sample_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_INIT:  if (init_row == ROW_W'(ROWS - 1)) state_next = ST_IDLE;
      ST_IDLE:  if (pend_full) state_next = ST_WRITE;
      ST_WRITE: state_next = ST_START;
      ST_START: state_next = ST_BUSY;
      ST_BUSY:  if (mac_done) state_next = ST_IDLE;
      default:  state_next = ST_INIT;
    endcase
  end

  always_comb begin
    init_done    = 1'b1;
    datain_ready = 1'b0;
    init_wr      = 1'b0;
    pend_wr      = 1'b0;
    unique case (state)
      ST_INIT: begin
        init_done = 1'b0;
        init_wr   = 1'b1;
      end
      ST_WRITE: pend_wr      = 1'b1;
      ST_START: datain_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr       <= '1;
      init_row  <= '0;
      pend_full <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (init_wr) init_row <= init_row + ROW_W'(1);
      if (pend_wr) ptr <= wr_idx;
      if (accept)       pend_full <= 1'b1;
      else if (pend_wr) pend_full <= 1'b0;
      if (sample_valid && !sample_ready) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) pend_data <= sample_in;
  end

  // Write side: INIT clears one row across all banks; WRITE stores one sample.
  assign wr_idx  = ptr + IDX_W'(1);
  assign wr_row  = init_wr ? init_row : wr_idx[IDX_W-1:2];
  assign wr_data = init_wr ? '0 : pend_data;

  for (genvar k = 0; k < LANES; k++) begin : g_bank
    logic [ROW_W-1:0] rd_row;

    // Banks above the pointer's lane sit one row behind the newest row.
    assign rd_row     = ptr[IDX_W-1:2] - rd_addr - ROW_W'(2'(k) > ptr[1:0]);
    assign bank_we[k] = init_wr | (pend_wr & (wr_idx[1:0] == 2'(k)));

    fir_sample_bank #(
      .DATA_W (DATA_W),
      .ROWS   (ROWS)
    ) u_bank (
      .clock (clock),
      .we    (bank_we[k]),
      .waddr (wr_row),
      .wdata (wr_data),
      .raddr (rd_row),
      .rdata (bank_q[k])
    );
  end

  // p0 -> p1: lane rotation travels with the bank read it steers.
  always_ff @(posedge clock) begin
    rot_p1 <= ptr[1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) rd_vld_p1 <= 1'b0;
    else       rd_vld_p1 <= init_done;
  end

  always_comb begin
    logic [1:0] sel;
    rd_data = '0;
    sel     = '0;
    if (rd_vld_p1) begin
      for (int j = 0; j < LANES; j++) begin
        sel = rot_p1 - 2'(j);
        rd_data[DATA_W*(LANES-j)-1 -: DATA_W] = bank_q[sel];
      end
    end
  end

endmodule

// File: tb/tb_fir_sample_buffer.sv
// Directed + randomized bench for fir_sample_buffer against a sample-history model.
module tb_fir_sample_buffer;

  logic               clock = 1'b0;
  logic               reset;
  logic signed [17:0] sample_in;
  logic               sample_valid;
  logic               sample_ready;
  logic               datain_ready;
  logic               mac_done;
  logic [11:0]        rd_addr;
  logic [71:0]        rd_data;
  logic               overrun;
  logic               init_done;

  int n_checks = 0;
  int n_fail   = 0;
  int dr_count = 0;

  logic [17:0] hist [16384];
  int          wr_count;

  fir_sample_buffer dut (
    .clock        (clock),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .datain_ready (datain_ready),
    .mac_done     (mac_done),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .overrun      (overrun),
    .init_done    (init_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (datain_ready === 1'b1) dr_count <= dr_count + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input logic [71:0] obs, input logic [71:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16384; i++) hist[i] = '0;
    wr_count = 0;
  endtask

  task automatic model_add(input logic [17:0] v);
    hist[wr_count % 16384] = v;
    wr_count++;
  endtask

  // Word a, lane j holds the sample written (4a+j) writes before the newest one.
  function automatic logic [71:0] model_word(input int a);
    logic [71:0] w;
    int idx;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      idx = (wr_count - 1 - 4 * a - j + 65536) % 16384;
      w[71 - 18 * j -: 18] = hist[idx];
    end
    return w;
  endfunction

  task automatic push(input logic [17:0] v);
    bit acc;
    acc = 1'b0;
    sample_in    = v;
    sample_valid = 1'b1;
    for (int c = 0; c < 20 && !acc; c++) begin
      if (sample_ready) begin
        acc = 1'b1;
        model_add(v);
      end
      tick();
    end
    sample_valid = 1'b0;
    chk(72'(acc), 72'd1, "accept");
  endtask

  task automatic wait_dr();
    for (int c = 0; c < 10 && !datain_ready; c++) tick();
    chk(72'(datain_ready), 72'd1, "datain_ready_seen");
  endtask

  task automatic check_rd(input int a, input string tag);
    rd_addr = 12'(a);
    tick();
    chk(rd_data, model_word(a), tag);
  endtask

  task automatic pulse_done();
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
  endtask

  task automatic wait_init();
    repeat (4095) tick();
    chk(72'(init_done), 72'd0, "init_done_early");
    tick();
    chk(72'(init_done), 72'd1, "init_done_4096");
    chk(72'(sample_ready), 72'd1, "ready_after_init");
  endtask

  initial begin
    int d0;
    logic [17:0] v;
    reset        = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    mac_done     = 1'b0;
    rd_addr      = '0;
    model_clear();
    repeat (3) tick();
    chk(72'(sample_ready), 72'd0, "rst_ready");
    chk(72'(datain_ready), 72'd0, "rst_dr");
    chk(72'(overrun), 72'd0, "rst_overrun");
    chk(72'(init_done), 72'd0, "rst_init_done");
    chk(rd_data, 72'd0, "rst_rd_data");
    reset = 1'b0;
    wait_init();

    // Whole buffer reads back as zero after initialisation.
    for (int a = 0; a < 4096; a++) begin
      rd_addr = 12'(a);
      tick();
      chk(rd_data, 72'd0, "zero_sweep");
    end

    // First sample: datain_ready exactly three cycles after acceptance.
    push(18'h00001);
    chk(72'(datain_ready), 72'd0, "dr_t1");
    tick();
    chk(72'(datain_ready), 72'd0, "dr_t2");
    tick();
    chk(72'(datain_ready), 72'd1, "dr_t3");
    tick();
    chk(72'(datain_ready), 72'd0, "dr_t4");
    rd_addr = 12'd0;
    tick();
    chk(rd_data, {18'd1, 18'd0, 18'd0, 18'd0}, "one_sample");
    pulse_done();

    for (int s = 2; s <= 5; s++) begin
      push(18'(s));
      wait_dr();
      tick();
      pulse_done();
    end
    rd_addr = 12'd0;
    tick();
    chk(rd_data, {18'd5, 18'd4, 18'd3, 18'd2}, "five_addr0");
    rd_addr = 12'd1;
    #1;
    chk(rd_data, {18'd5, 18'd4, 18'd3, 18'd2}, "read_latency_hold");
    tick();
    chk(rd_data, {18'd1, 18'd0, 18'd0, 18'd0}, "five_addr1");
    chk(72'(overrun), 72'd0, "no_overrun");

    // Random samples with varying MAC latency and stray mac_done in IDLE.
    for (int it = 0; it < 24; it++) begin
      if (it % 3 == 0) pulse_done();
      v = 18'($urandom);
      push(v);
      wait_dr();
      tick();
      repeat ($urandom_range(0, 3)) tick();
      check_rd($urandom_range(0, 3), "rand_near");
      check_rd($urandom_range(0, 4095), "rand_far");
      pulse_done();
    end

    // Samples during BUSY: one held, the rest dropped.
    push(18'h2aaaa);
    wait_dr();
    tick();
    sample_valid = 1'b1;
    sample_in    = 18'sh01234;
    chk(72'(sample_ready), 72'd1, "busy_ready_first");
    tick();
    model_add(18'h01234);
    sample_in = 18'sh05678;
    chk(72'(sample_ready), 72'd0, "busy_ready_second");
    tick();
    sample_in = 18'sh09abc;
    tick();
    sample_valid = 1'b0;
    chk(72'(overrun), 72'd1, "overrun_set");
    d0 = dr_count;
    repeat (5) tick();
    chk(72'(dr_count - d0), 72'd0, "no_write_in_busy");
    pulse_done();
    repeat (8) tick();
    chk(72'(dr_count - d0), 72'd1, "one_more_dr");
    check_rd(0, "held_sample_written");
    pulse_done();

    // Reset during BUSY with a pending sample.
    push(18'h00777);
    wait_dr();
    tick();
    sample_valid = 1'b1;
    sample_in    = 18'sh00888;
    tick();
    sample_valid = 1'b0;
    chk(72'(sample_ready), 72'd0, "pending_full");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    chk(72'(sample_ready), 72'd0, "rst2_ready");
    chk(72'(init_done), 72'd0, "rst2_init_done");
    chk(72'(overrun), 72'd0, "rst2_overrun");
    chk(rd_data, 72'd0, "rst2_rd_data");
    d0 = dr_count;
    wait_init();
    chk(72'(dr_count - d0), 72'd0, "rst2_no_dr_init");
    repeat (6) tick();
    chk(72'(dr_count - d0), 72'd0, "rst2_pending_gone");
    check_rd(0, "rst2_zero");

    // Fill past one full wrap with value = index + 1.
    mac_done = 1'b1;
    for (int n = 0; n < 16385; n++) push(18'(n + 1));
    repeat (8) tick();
    mac_done = 1'b0;
    check_rd(0, "wrap_addr0");
    chk(72'(rd_data[71:54]), 72'd16385, "wrap_newest");
    chk(72'(rd_data[53:36]), 72'd16384, "wrap_ptr_zero");
    check_rd(4095, "wrap_addr4095");
    chk(72'(rd_data[17:0]), 72'd2, "wrap_oldest");
    for (int i = 0; i < 8; i++) check_rd($urandom_range(0, 4095), "wrap_rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
